serial_adder_ctrl: RTL and testbench
====================================

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand bit count; legal range is 1..32.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port start  input  1  request to begin an addition; sampled on the rising edge of clk.
REQ-005 The block SHALL have ports a and b  input  WIDTH each  unsigned operands.
REQ-006 The block SHALL have port cin  input  1  carry-in into bit 0.
REQ-007 The block SHALL have port busy  output  1  high while bits are being computed.
REQ-008 The block SHALL have port done  output  1  one-cycle pulse marking a completed result.
REQ-009 The block SHALL have ports sum  output  WIDTH  and cout  output  1: the last completed result and its carry-out.

Function
REQ-010 The block SHALL compute a+b+cin one bit per cycle, LSB first, using one full-adder cell: s = x^y^c and c' = (x&y)|(c&(x^y)).
REQ-011 The FSM SHALL have three states, IDLE, RUN and DONE, and SHALL enter IDLE on reset.
REQ-012 In IDLE, start=1 at an edge SHALL latch a, b and cin into internal registers, clear the bit counter, and move to RUN.
REQ-013 In RUN, each edge SHALL:
- process operand bit[counter];
- shift the bit result into an internal shift register;
- update the internal carry;
- increment the counter.
REQ-014 At the RUN edge that processes bit WIDTH-1, the FSM SHALL move to DONE and, on that same edge, load sum and cout with the full result.
REQ-015 From DONE, the FSM SHALL return to IDLE on the next edge unconditionally.
REQ-016 Latency: if start is accepted at edge 0, sum and cout SHALL be valid after edge WIDTH, and done SHALL be high during the cycle between edge WIDTH and edge WIDTH+1.
REQ-017 busy SHALL be 1 exactly while in RUN, and done SHALL be 1 exactly while in DONE; the two SHALL never be high together.
REQ-018 start SHALL be ignored in RUN and in DONE; the earliest next acceptance is the edge after DONE.
REQ-019 Changes on a, b or cin after acceptance SHALL NOT affect the result in progress.
REQ-020 sum and cout SHALL hold their values until the next completion; partial results SHALL never appear on them.
REQ-021 WIDTH=1 SHALL work: one RUN cycle, then DONE.
REQ-022 The result SHALL wrap modulo 2^WIDTH, with the carry out of the MSB reported on cout.

Reset
REQ-023 rst_n low SHALL immediately, without waiting for clk:
- force the state to IDLE;
- clear busy, done, sum, cout, the counter, the internal carry and the operand registers.
REQ-024 A reset during RUN SHALL abandon the operation with no done pulse, and start SHALL be accepted on the first edge after rst_n rises.

Configuration
REQ-025 When macro SERIAL_ADDER_OVF_EN is defined, the block SHALL add output port ovf  1  signed-overflow flag, equal to (carry into MSB) XOR (carry out of MSB).
REQ-026 ovf SHALL be loaded together with sum and cout, SHALL be held until the next completion, and SHALL reset to 0.
REQ-027 When SERIAL_ADDER_OVF_EN is undefined, port ovf and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (WIDTH=8)
REQ-028 a=0x0F, b=0x01, cin=0, start accepted at edge 0 -> busy high for edges 1..8, done high only after edge 8, sum=0x10, cout=0.
REQ-029 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xAA, b=0x55, cin=1 -> sum=0x00, cout=1.
REQ-030 With macro defined, a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1; a=0xFF, b=0x01 -> ovf=0.
REQ-031 start pulsed at RUN cycle 3 while a, b change -> ignored, with result equal to the originally latched operands.
REQ-032 rst_n low at RUN cycle 4 -> busy=0, done=0, sum=0x00, cout=0 at once, with no done pulse; after release, a=0x03, b=0x04, cin=1 -> sum=0x08.
REQ-033 Back-to-back requests with start held high -> second operation accepted at the edge after DONE, giving done pulses exactly 10 cycles apart.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
// Bit-serial adder: computes a + b + cin one bit per clock, LSB first,
// through a single full-adder cell. A three-state FSM (IDLE/RUN/DONE)
// sequences the operation; sum/cout only change when a result completes.
//
// Optional feature: define SERIAL_ADDER_OVF_EN to add the 'ovf' output,
// the signed-overflow flag (carry into MSB xor carry out of MSB).

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Counter wide enough to index bits 0..WIDTH-1 (at least one bit).
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Operands captured at acceptance, so later input changes cannot
  // disturb an addition in progress.
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry;
  logic [CW-1:0]    cnt;

  // Partial result: each new bit enters at the MSB and the register
  // shifts right, so after WIDTH steps bit 0 has landed at position 0.
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] sh_next;

  logic bit_a;
  logic bit_b;
  logic bit_s;
  logic carry_next;
  logic last_bit;

  // Operand bit selection; a 1-bit operand has only bit 0 to offer.
  generate
    if (WIDTH == 1) begin : g_sel_one
      assign bit_a = a_reg[0];
      assign bit_b = b_reg[0];
    end else begin : g_sel_multi
      assign bit_a = a_reg[cnt];
      assign bit_b = b_reg[cnt];
    end
  endgenerate

  // Full-adder cell plus the shifted partial result it produces.
  always_comb begin
    bit_s      = bit_a ^ bit_b ^ carry;
    carry_next = (bit_a & bit_b) | (carry & (bit_a ^ bit_b));
    last_bit   = (cnt == LAST_BIT);
    sh_next    = shreg >> 1;
    sh_next[WIDTH-1] = bit_s;
  end

  // FSM state register; reset returns to IDLE without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and the state-decoded busy/done flags.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Working registers: capture operands on acceptance, then step one bit
  // per cycle while running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      shreg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            carry <= cin;
            cnt   <= '0;
            shreg <= '0;
          end
        end
        RUN: begin
          shreg <= sh_next;
          carry <= carry_next;
          if (last_bit) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Result registers: loaded only on the step that finishes the MSB, so
  // partial results never show on the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
    end else if (state == RUN && last_bit) begin
      sum  <= sh_next;
      cout <= carry_next;
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  // Signed overflow: the carry entering the MSB differs from the one leaving it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (state == RUN && last_bit) begin
      ovf <= carry ^ carry_next;
    end
  end
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl
// Directed bench for serial_adder_ctrl (WIDTH=8 main instance plus a
// WIDTH=1 instance). Inputs are driven and outputs sampled on the falling
// clock edge. Define SERIAL_ADDER_OVF_EN to also check the ovf output.

module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       cin1;
  logic       busy1;
  logic       done1;
  logic [0:0] sum1;
  logic       cout1;

`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf;
  logic       ovf1;
`endif

  int nChecks = 0;
  int nErrors = 0;

  logic [7:0] lastSum = 8'h00;
  logic       lastCout = 1'b0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  serial_adder_ctrl #(.WIDTH(1)) u_dut_w1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .cin   (cin1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf1)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present operands with start high for one rising edge; returns at the
  // falling edge just after the accepting edge.
  task automatic applyStimulus(input logic [7:0] va, input logic [7:0] vb, input logic vc);
    @(negedge clk);
    a     = va;
    b     = vb;
    cin   = vc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic checkResult(input string tag, input logic [7:0] esum, input logic ecout, input logic eovf);
    checkOutput({tag, " sum"}, sum, esum);
    checkOutput({tag, " cout"}, cout, ecout);
`ifdef SERIAL_ADDER_OVF_EN
    checkOutput({tag, " ovf"}, ovf, eovf);
`else
    $display("[TB] %s: expected ovf %0b (ovf output not built)", tag, eovf);
`endif
    lastSum  = esum;
    lastCout = ecout;
  endtask

  // Bounded wait for the done pulse; an expired bound counts as a miscompare.
  task automatic waitDone(input string tag, input int maxCycles);
    int cycles;
    cycles = 0;
    while (!done && cycles < maxCycles) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput({tag, " done seen"}, done, 1'b1);
  endtask

  // Full operation with cycle-exact busy/done/hold checks.
  task automatic runOp(input string tag, input logic [7:0] va, input logic [7:0] vb, input logic vc,
                       input logic [7:0] esum, input logic ecout, input logic eovf);
    applyStimulus(va, vb, vc);
    for (int k = 0; k < 8; k++) begin
      checkOutput({tag, " busy run"}, busy, 1'b1);
      checkOutput({tag, " done run"}, done, 1'b0);
      checkOutput({tag, " sum held"}, sum, lastSum);
      checkOutput({tag, " cout held"}, cout, lastCout);
      @(negedge clk);
    end
    checkOutput({tag, " busy at done"}, busy, 1'b0);
    checkOutput({tag, " done pulse"}, done, 1'b1);
    checkResult(tag, esum, ecout, eovf);
    @(negedge clk);
    checkOutput({tag, " done ends"}, done, 1'b0);
    checkOutput({tag, " busy idle"}, busy, 1'b0);
    checkOutput({tag, " sum kept"}, sum, esum);
  endtask

  initial begin
    int t;
    int d1;
    int d2;
    logic [7:0] s1;
    logic [7:0] s2;

    rst_n  = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    cin    = 1'b0;
    start1 = 1'b0;
    a1     = '0;
    b1     = '0;
    cin1   = 1'b0;

    // Reset state
    #12;
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset done", done, 1'b0);
    checkOutput("reset sum", sum, 8'h00);
    checkOutput("reset cout", cout, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
    checkOutput("reset ovf", ovf, 1'b0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Basic additions, including wrap and carry chains through every bit
    runOp("0F+01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    runOp("FF+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    runOp("AA+55+1", 8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0);
    runOp("7F+01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);

    // start and operand changes mid-run must be ignored
    applyStimulus(8'h12, 8'h34, 1'b0);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    a     = 8'hFF;
    b     = 8'hFF;
    cin   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("ignore busy", busy, 1'b1);
    waitDone("ignore", 12);
    checkResult("ignore", 8'h46, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("ignore back idle", busy, 1'b0);
    checkOutput("ignore done ends", done, 1'b0);

    // Asynchronous reset in the middle of a run
    applyStimulus(8'h55, 8'h22, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort busy", busy, 1'b0);
    checkOutput("abort done", done, 1'b0);
    checkOutput("abort sum", sum, 8'h00);
    checkOutput("abort cout", cout, 1'b0);
    lastSum  = 8'h00;
    lastCout = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("abort no done", done, 1'b0);
    end
    rst_n = 1'b1;
    a     = 8'h03;
    b     = 8'h04;
    cin   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("post reset accept", busy, 1'b1);
    waitDone("post reset", 12);
    checkResult("post reset", 8'h08, 1'b0, 1'b0);
    @(negedge clk);

    // Back-to-back requests with start held high
    a     = 8'h10;
    b     = 8'h20;
    cin   = 1'b0;
    start = 1'b1;
    t  = 0;
    d1 = -1;
    d2 = -1;
    s1 = '0;
    s2 = '0;
    while (d2 < 0 && t < 40) begin
      @(negedge clk);
      t++;
      if (t == 1) begin
        a = 8'h01;
        b = 8'h02;
      end
      if (done) begin
        if (d1 < 0) begin
          d1 = t;
          s1 = sum;
        end else begin
          d2 = t;
          s2 = sum;
        end
      end
    end
    start = 1'b0;
    checkOutput("b2b first done", (d1 >= 0), 1'b1);
    checkOutput("b2b second done", (d2 >= 0), 1'b1);
    checkOutput("b2b spacing", d2 - d1, 10);
    checkOutput("b2b first sum", s1, 8'h30);
    checkOutput("b2b second sum", s2, 8'h03);
    @(negedge clk);
    @(negedge clk);

    // WIDTH=1: one RUN cycle, then DONE
    start1 = 1'b1;
    a1     = 1'b1;
    b1     = 1'b1;
    cin1   = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    checkOutput("w1 busy", busy1, 1'b1);
    checkOutput("w1 no done yet", done1, 1'b0);
    @(negedge clk);
    checkOutput("w1 busy at done", busy1, 1'b0);
    checkOutput("w1 done", done1, 1'b1);
    checkOutput("w1 sum 1+1+1", sum1, 1'b1);
    checkOutput("w1 cout 1+1+1", cout1, 1'b1);
`ifdef SERIAL_ADDER_OVF_EN
    checkOutput("w1 ovf 1+1+1", ovf1, 1'b0);
`endif
    @(negedge clk);
    checkOutput("w1 done ends", done1, 1'b0);
    start1 = 1'b1;
    a1     = 1'b0;
    b1     = 1'b0;
    cin1   = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    checkOutput("w1 done 0+0+1", done1, 1'b1);
    checkOutput("w1 sum 0+0+1", sum1, 1'b1);
    checkOutput("w1 cout 0+0+1", cout1, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
    checkOutput("w1 ovf 0+0+1", ovf1, 1'b1);
`endif
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErrors);
    $finish;
  end

endmodule
